// File: rtl/pingpong_write_ctrl.sv
// Ping-pong write controller: counts handshaked words into frames and steers
// consecutive frames to alternating banks, stalling when the next bank is still full.
module pingpong_write_ctrl #(
    parameter int WORD_SIZE   = 16,
    parameter int FRAME_WORDS = 784,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_SIZE-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            bank_release,
    output logic [WORD_SIZE-1:0]  data_out,
    output logic                  sel,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [1:0]            bank_full,
    output logic                  frame_done
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready is a function of registered state only and never of in_valid.

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    logic                  cur_bank_q,   cur_bank_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q,   word_cnt_d;
    logic [1:0]            bank_full_q,  bank_full_d;
    logic [WORD_SIZE-1:0]  data_out_q,   data_out_d;
    logic                  sel_q,        sel_d;
    logic                  wr_en_q,      wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,    wr_addr_d;
    logic                  frame_done_q, frame_done_d;

    logic [0:0] state;
    logic       accept;
    logic       last_word;

    // WAIT means the bank we would write next still holds an unreleased frame.
    assign state     = bank_full_q[cur_bank_q] ? ST_WAIT : ST_FILL;
    assign in_ready  = (state == ST_FILL);
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (word_cnt_q == LAST_ADDR);

    always_comb begin
        cur_bank_d   = cur_bank_q;
        word_cnt_d   = word_cnt_q;
        data_out_d   = data_out_q;
        sel_d        = sel_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;

        if (accept) begin
            data_out_d = in_data;
            sel_d      = cur_bank_q;
            wr_addr_d  = word_cnt_q;
            wr_en_d    = 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
            if (last_word) begin
                word_cnt_d   = '0;
                cur_bank_d   = ~cur_bank_q;
                frame_done_d = 1'b1;
            end
        end
    end

    // Set has priority over release so a spurious release can never drop a frame.
    always_comb begin
        bank_full_d = bank_full_q;
        for (int i = 0; i < 2; i++) begin
            if (last_word && (cur_bank_q == 1'(i))) begin
                bank_full_d[i] = 1'b1;
            end else if (bank_release[i]) begin
                bank_full_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_bank_q   <= 1'b0;
            word_cnt_q   <= '0;
            bank_full_q  <= 2'b00;
            data_out_q   <= '0;
            sel_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cur_bank_q   <= cur_bank_d;
            word_cnt_q   <= word_cnt_d;
            bank_full_q  <= bank_full_d;
            data_out_q   <= data_out_d;
            sel_q        <= sel_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_out   = data_out_q;
    assign sel        = sel_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign bank_full  = bank_full_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pingpong_write_ctrl.sv
// Bench for pingpong_write_ctrl with 4-word frames: directed table, hand sequences
// and random traffic checked against a word-count based reference model.
module tb_pingpong_write_ctrl;

    localparam int WS = 16;
    localparam int FW = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [WS-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    bank_release = 2'b00;
    logic [WS-1:0] data_out;
    logic          sel;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    bank_full;
    logic          frame_done;

    pingpong_write_ctrl #(.WORD_SIZE(WS), .FRAME_WORDS(FW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bank_release(bank_release), .data_out(data_out),
        .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr), .bank_full(bank_full),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic          sel;
        logic [AW-1:0] addr;
        logic [WS-1:0] dout;
        logic          fd;
        logic [1:0]    bf;
        logic          rdy;
    } out_t;

    typedef struct packed {
        logic          v;
        logic [WS-1:0] d;
        logic [1:0]    rel;
        out_t          o;
    } vec_t;

    localparam out_t RESET_OUT = '{we: 1'b0, sel: 1'b0, addr: 2'd0, dout: 16'h0,
                                   fd: 1'b0, bf: 2'b00, rdy: 1'b1};

    int checks = 0;
    int errors = 0;

    // Reference model: everything follows from the total number of accepted words.
    int         m_n;
    logic [1:0] m_full;
    out_t       m_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t e);
        chk({tag, ".wr_en"},      32'(wr_en),      32'(e.we));
        chk({tag, ".sel"},        32'(sel),        32'(e.sel));
        chk({tag, ".wr_addr"},    32'(wr_addr),    32'(e.addr));
        chk({tag, ".data_out"},   32'(data_out),   32'(e.dout));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(e.fd));
        chk({tag, ".bank_full"},  32'(bank_full),  32'(e.bf));
        chk({tag, ".in_ready"},   32'(in_ready),   32'(e.rdy));
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_full = 2'b00;
        m_o    = RESET_OUT;
    endtask

    task automatic model_step(input logic v, input logic [WS-1:0] d, input logic [1:0] rel);
        int b;
        b = (m_n / FW) % 2;
        m_o.we = v && !m_full[b];
        m_o.fd = 1'b0;
        if (m_o.we) begin
            m_o.sel  = b[0];
            m_o.addr = AW'(m_n % FW);
            m_o.dout = d;
            m_o.fd   = (m_n % FW) == FW - 1;
            m_n++;
        end
        for (int i = 0; i < 2; i++)
            if (rel[i]) m_full[i] = 1'b0;
        if (m_o.fd) m_full[m_o.sel] = 1'b1;
        m_o.bf  = m_full;
        m_o.rdy = !m_full[(m_n / FW) % 2];
    endtask

    task automatic cyc(input logic v, input logic [WS-1:0] d, input logic [1:0] rel,
                       input string tag);
        in_valid     = v;
        in_data      = d;
        bank_release = rel;
        model_step(v, d, rel);
        @(posedge clk);
        #1;
        cmp_out(tag, m_o);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        bank_release = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        cmp_out("reset", RESET_OUT);
        reset = 1'b0;
        model_reset();
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 16'h0001, 2'b00, '{1'b1, 1'b0, 2'd0, 16'h0001, 1'b0, 2'b00, 1'b1}};
        tbl[1]  = '{1'b1, 16'h0002, 2'b00, '{1'b1, 1'b0, 2'd1, 16'h0002, 1'b0, 2'b00, 1'b1}};
        tbl[2]  = '{1'b1, 16'h0003, 2'b00, '{1'b1, 1'b0, 2'd2, 16'h0003, 1'b0, 2'b00, 1'b1}};
        tbl[3]  = '{1'b1, 16'h0004, 2'b00, '{1'b1, 1'b0, 2'd3, 16'h0004, 1'b1, 2'b01, 1'b1}};
        tbl[4]  = '{1'b1, 16'h0005, 2'b00, '{1'b1, 1'b1, 2'd0, 16'h0005, 1'b0, 2'b01, 1'b1}};
        tbl[5]  = '{1'b1, 16'h0006, 2'b00, '{1'b1, 1'b1, 2'd1, 16'h0006, 1'b0, 2'b01, 1'b1}};
        tbl[6]  = '{1'b1, 16'h0007, 2'b00, '{1'b1, 1'b1, 2'd2, 16'h0007, 1'b0, 2'b01, 1'b1}};
        tbl[7]  = '{1'b1, 16'h0008, 2'b00, '{1'b1, 1'b1, 2'd3, 16'h0008, 1'b1, 2'b11, 1'b0}};
        tbl[8]  = '{1'b1, 16'h0009, 2'b00, '{1'b0, 1'b1, 2'd3, 16'h0008, 1'b0, 2'b11, 1'b0}};
        tbl[9]  = '{1'b1, 16'h0009, 2'b01, '{1'b0, 1'b1, 2'd3, 16'h0008, 1'b0, 2'b10, 1'b1}};
        tbl[10] = '{1'b1, 16'h0009, 2'b00, '{1'b1, 1'b0, 2'd0, 16'h0009, 1'b0, 2'b10, 1'b1}};

        do_reset();

        // Directed table: two full frames, stall, release of bank 0, resume.
        for (int i = 0; i < 11; i++) begin
            in_valid     = tbl[i].v;
            in_data      = tbl[i].d;
            bank_release = tbl[i].rel;
            model_step(tbl[i].v, tbl[i].d, tbl[i].rel);
            @(posedge clk);
            #1;
            cmp_out($sformatf("tbl%0d", i), tbl[i].o);
        end

        // in_valid toggling every other cycle; bank 1 released midway.
        for (int i = 0; i < 16; i++)
            cyc(1'(i % 2), 16'h0100 + 16'(i), (i == 10) ? 2'b10 : 2'b00, "toggle");

        // Random traffic with occasional releases of either or both banks.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] rel;
            rel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cyc(1'($urandom_range(0, 1)), 16'($urandom), rel, "rand");
        end

        // Spurious release of an empty bank is ignored.
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'h0A00 + 16'(i), 2'b00, "fill0");
        cyc(1'b0, 16'h0, 2'b10, "spurious");
        chk("spurious.bank_full_const", 32'(bank_full), 32'h1);

        // Release of the bank being completed in the same cycle: set wins.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'h0B00 + 16'(i), (i == 3) ? 2'b10 : 2'b00, "setwins");
        chk("setwins.bank_full_const", 32'(bank_full), 32'h3);

        // Asynchronous reset after two words of a frame.
        do_reset();
        cyc(1'b1, 16'h0C00, 2'b00, "mid0");
        cyc(1'b1, 16'h0C01, 2'b00, "mid1");
        in_valid = 1'b0;
        reset    = 1'b1;
        #2;
        cmp_out("async_reset", RESET_OUT);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'h0D00 + 16'(i), 2'b00, "after_reset");
        chk("after_reset.bank_full_const", 32'(bank_full), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
